// File: rtl/mux_nch_scan.sv
// mux_nch_scan: N-channel, WIDTH-bit multiplexer with a registered output.
// A channel is chosen either by an external select (manual mode) or by an
// internal scanner that dwells DWELL enabled cycles on each channel in turn.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        cycle enable; when low all state holds and the pulses clear
//   mode      0 = manual, 1 = scan
//   sel_in    manual channel select
//   inp       packed channel data, channel k at [k*WIDTH +: WIDTH]
//   outp      registered selected data
//   sel_cur   channel currently shown on outp
//   out_valid outp was updated on the last edge
//   wrap      one-cycle pulse when the scan index wraps NCH-1 -> 0
//   err       one-cycle pulse on an out-of-range manual select
module mux_nch_scan #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_in,
  input  logic [NCH*WIDTH-1:0] inp,
  output logic [WIDTH-1:0]     outp,
  output logic [SELW-1:0]      sel_cur,
  output logic                 out_valid,
  output logic                 wrap,
  output logic                 err
);

  localparam int DCW = $clog2(DWELL + 1);
  localparam int NSLOT = 2 ** SELW;
  localparam logic [SELW:0]   NCH_C      = (SELW + 1)'(NCH);
  localparam logic [SELW-1:0] LAST_IDX   = SELW'(NCH - 1);
  localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MANUAL = 2'd1, SCAN = 2'd2} state_t;

  // Channel table padded to the full select range so any select value is a
  // legal index; unused slots read as zero and are never captured.
  logic [WIDTH-1:0] chan [NSLOT];

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_chan
      if (gi < NCH) begin : g_used
        assign chan[gi] = inp[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] outp_reg, outp_next;
  logic [SELW-1:0] sel_cur_reg, sel_cur_next;
  logic [SELW-1:0] scan_idx_reg, scan_idx_next;
  logic [DCW-1:0]  dwell_cnt_reg, dwell_cnt_next;
  logic            wrap_reg, wrap_next;
  logic            err_reg, err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      outp_reg      <= '0;
      sel_cur_reg   <= '0;
      scan_idx_reg  <= '0;
      dwell_cnt_reg <= '0;
      wrap_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      outp_reg      <= outp_next;
      sel_cur_reg   <= sel_cur_next;
      scan_idx_reg  <= scan_idx_next;
      dwell_cnt_reg <= dwell_cnt_next;
      wrap_reg      <= wrap_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = IDLE;
    outp_next      = outp_reg;
    sel_cur_next   = sel_cur_reg;
    scan_idx_next  = scan_idx_reg;
    dwell_cnt_next = dwell_cnt_reg;
    wrap_next      = 1'b0;
    err_next       = 1'b0;

    if (en) begin
      if (!mode) begin
        state_next     = MANUAL;
        // Zeroed counters make a later switch to scan start at channel 0
        // with a full dwell.
        scan_idx_next  = '0;
        dwell_cnt_next = '0;
        if ({1'b0, sel_in} < NCH_C) begin
          outp_next    = chan[sel_in];
          sel_cur_next = sel_in;
        end else begin
          err_next     = 1'b1;
        end
      end else begin
        state_next   = SCAN;
        outp_next    = chan[scan_idx_reg];
        sel_cur_next = scan_idx_reg;
        if (dwell_cnt_reg == DWELL_LAST) begin
          dwell_cnt_next = '0;
          if (scan_idx_reg == LAST_IDX) begin
            scan_idx_next = '0;
            wrap_next     = 1'b1;
          end else begin
            scan_idx_next = scan_idx_reg + SELW'(1);
          end
        end else begin
          dwell_cnt_next = dwell_cnt_reg + DCW'(1);
        end
      end
    end
  end

  // outp was refreshed on the last edge exactly when that edge was a scan
  // edge or a manual edge with a legal select.
  assign out_valid = (state_reg == SCAN) || ((state_reg == MANUAL) && !err_reg);
  assign outp      = outp_reg;
  assign sel_cur   = sel_cur_reg;
  assign wrap      = wrap_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mux_nch_scan.sv
module tb_mux_nch_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [1:0]  sel_in;
  logic [31:0] inp;

  logic [7:0]  outp_a,  outp_b;
  logic [1:0]  sel_cur_a, sel_cur_b;
  logic        out_valid_a, out_valid_b;
  logic        wrap_a, wrap_b;
  logic        err_a, err_b;

  always #5 clk = ~clk;

  // A: default 4 channels, dwell 4.  B: 3 channels (non power of two), dwell 2.
  mux_nch_scan #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .inp(inp), .outp(outp_a), .sel_cur(sel_cur_a), .out_valid(out_valid_a),
    .wrap(wrap_a), .err(err_a)
  );

  mux_nch_scan #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .inp(inp[23:0]), .outp(outp_b), .sel_cur(sel_cur_b), .out_valid(out_valid_b),
    .wrap(wrap_b), .err(err_b)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_check = 0;

  // Reference model: scan position is the number of scan edges since the
  // counters were last cleared; the channel and wrap follow from division.
  int       nch_m [2] = '{4, 3};
  int       dw_m  [2] = '{4, 2};
  int       cnt_m [2];
  logic [7:0] out_m [2];
  int       sel_m [2];
  bit       valid_m [2];
  bit       wrap_m  [2];
  bit       err_m   [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt_m[d] = 0; out_m[d] = '0; sel_m[d] = 0;
      valid_m[d] = 0; wrap_m[d] = 0; err_m[d] = 0;
    end
  endtask

  task automatic model_edge();
    int ch;
    int period;
    for (int d = 0; d < 2; d++) begin
      if (!en) begin
        valid_m[d] = 0; wrap_m[d] = 0; err_m[d] = 0;
      end else if (!mode) begin
        cnt_m[d]  = 0;
        wrap_m[d] = 0;
        if (int'(sel_in) < nch_m[d]) begin
          out_m[d] = inp[int'(sel_in)*8 +: 8];
          sel_m[d] = int'(sel_in);
          valid_m[d] = 1; err_m[d] = 0;
        end else begin
          valid_m[d] = 0; err_m[d] = 1;
        end
      end else begin
        period     = dw_m[d] * nch_m[d];
        ch         = (cnt_m[d] / dw_m[d]) % nch_m[d];
        out_m[d]   = inp[ch*8 +: 8];
        sel_m[d]   = ch;
        valid_m[d] = 1; err_m[d] = 0;
        wrap_m[d]  = (cnt_m[d] % period) == (period - 1);
        cnt_m[d]   = cnt_m[d] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, " a.outp"},      {24'b0, outp_a},      {24'b0, out_m[0]});
    chk({ctx, " a.sel_cur"},   {30'b0, sel_cur_a},   sel_m[0]);
    chk({ctx, " a.out_valid"}, {31'b0, out_valid_a}, {31'b0, valid_m[0]});
    chk({ctx, " a.wrap"},      {31'b0, wrap_a},      {31'b0, wrap_m[0]});
    chk({ctx, " a.err"},       {31'b0, err_a},       {31'b0, err_m[0]});
    chk({ctx, " b.outp"},      {24'b0, outp_b},      {24'b0, out_m[1]});
    chk({ctx, " b.sel_cur"},   {30'b0, sel_cur_b},   sel_m[1]);
    chk({ctx, " b.out_valid"}, {31'b0, out_valid_b}, {31'b0, valid_m[1]});
    chk({ctx, " b.wrap"},      {31'b0, wrap_b},      {31'b0, wrap_m[1]});
    chk({ctx, " b.err"},       {31'b0, err_b},       {31'b0, err_m[1]});
  endtask

  // One clock edge: update the model with the inputs present at the edge,
  // then sample the DUTs 1 time unit later.
  task automatic step(input string ctx);
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check_all(ctx);
    $display("%s: en=%0d mode=%0d sel_in=%0d inp=%08h -> a.outp=%02h a.sel=%0d b.outp=%02h b.sel=%0d",
             ctx, en, mode, sel_in, inp, outp_a, sel_cur_a, outp_b, sel_cur_b);
  endtask

  int wrap_count;
  int wrap_edge;

  initial begin
    model_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel_in = 2'd0; inp = 32'hDDCCBBAA;

    // Reset held across several edges: everything stays clear.
    for (int i = 0; i < 3; i++) step("reset");
    rst_n = 1'b1;
    step("first_after_reset");
    chk("first_after_reset a.outp", {24'b0, outp_a}, 32'hAA);

    // Manual sweep.
    inp = 32'h44332211; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel_in = 2'(i);
      step("manual_sweep");
    end

    // Scan wrap: 20 scan edges from cleared counters.
    mode = 1'b1; wrap_count = 0; wrap_edge = -1;
    for (int i = 1; i <= 20; i++) begin
      step("scan_wrap");
      if (wrap_a) begin wrap_count++; wrap_edge = i; end
    end
    chk("scan_wrap a.wrap_count", wrap_count, 1);
    chk("scan_wrap a.wrap_edge", wrap_edge, 16);

    // Enable pause mid channel 2.
    mode = 1'b0; step("pause_clear");
    mode = 1'b1;
    for (int i = 0; i < 10; i++) step("pause_pre");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = 1'(i & 1);
      step("pause_hold");
    end
    en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 8; i++) step("pause_resume");

    // Invalid select on the 3-channel instance.
    inp = 32'h99887766; mode = 1'b0; sel_in = 2'd1; step("invalid_prior");
    sel_in = 2'd3; step("invalid_sel");
    chk("invalid_sel b.err", {31'b0, err_b}, 32'd1);
    chk("invalid_sel b.outp_held", {24'b0, outp_b}, 32'h77);
    sel_in = 2'd0; step("invalid_after");

    // Asynchronous reset mid-scan while channel 2 is shown.
    mode = 1'b0; step("async_clear");
    mode = 1'b1;
    for (int i = 0; i < 9; i++) step("async_pre");
    chk("async_pre a.sel_cur", {30'b0, sel_cur_a}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("async_restart");

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      mode   = ($urandom_range(0, 3) != 0);
      sel_in = 2'($urandom_range(0, 3));
      inp    = $urandom;
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout n_check=%0d", n_check);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_nch_scan.md
Name: mux_nch_scan

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output. Successor to the combinational 2:1 mux.
- Two selection modes:
  - manual: an external select picks the channel.
  - scan: an internal dwell counter steps through channels 0..NCH-1 and wraps.
- Sits between multi-source data producers and a single downstream consumer. Reports the selected channel and a wrap pulse.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, channel count; legal range 2..16.
- SELW, 2, select width; must equal ceil(log2(NCH)).
- DWELL, 4, enabled cycles spent on each channel in scan mode; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  cycle enable; when 0 all state holds.
- mode  input  1  0 = manual, 1 = scan.
- sel_in  input  SELW  manual channel select.
- inp  input  NCH*WIDTH  packed channel data; channel k is bits [k*WIDTH +: WIDTH].
- outp  output  WIDTH  registered selected data.
- sel_cur  output  SELW  channel currently shown on outp.
- out_valid  output  1  outp was updated on the last edge.
- wrap  output  1  one-cycle pulse when scan index wraps NCH-1 -> 0.
- err  output  1  one-cycle pulse on an out-of-range manual select.

Behaviour:
- Reset (rst_n low, asynchronous): outp=0, sel_cur=0, out_valid=0, wrap=0, err=0, scan_idx=0, dwell_cnt=0, state=IDLE. Outputs hold these values while rst_n is low. Reset asserted mid-scan aborts immediately. After release, the first enabled edge behaves as from reset.
- States:
  - IDLE: entered on reset, or on any edge with en=0.
  - MANUAL: entered on an edge with en=1, mode=0.
  - SCAN: entered on an edge with en=1, mode=1.
- en=0 edge: outp and sel_cur hold; out_valid, wrap and err go to 0; scan_idx and dwell_cnt hold. Scan resumes where it paused.
- Latency: 1 clock. An input sampled at edge N appears on outp after edge N.
- MANUAL, sel_in < NCH: outp <= inp[sel_in], sel_cur <= sel_in, out_valid <= 1, err <= 0.
- MANUAL, sel_in >= NCH (possible only when NCH is not a power of 2): outp and sel_cur hold, out_valid <= 0, err <= 1.
- MANUAL, counters: scan_idx and dwell_cnt are forced to 0.
- SCAN, each enabled edge:
  - outp <= inp[scan_idx], sel_cur <= scan_idx, out_valid <= 1, err <= 0; sel_in is ignored.
  - If dwell_cnt == DWELL-1: dwell_cnt <= 0 and scan_idx <= (scan_idx == NCH-1) ? 0 : scan_idx+1.
  - Otherwise: dwell_cnt <= dwell_cnt+1.
  - wrap <= 1 on the edge where scan_idx moves NCH-1 -> 0; else wrap <= 0.
- Mode switch MANUAL -> SCAN: scan starts at channel 0 with a full dwell, because counters were held at 0.
- Mode switch SCAN -> MANUAL: takes effect on the same edge; scan progress is discarded.
- DWELL=1: channel advances every enabled edge. With NCH=4, wrap fires once every 4 enabled edges.
- Simultaneous cases:
  - mode change plus en=0: en dominates (hold).
  - Input data changing on the same edge it is sampled: the value present at the edge is captured.
- Widths: dwell_cnt is ceil(log2(DWELL+1)) bits. No arithmetic on data, which is passed unmodified.

Test Plan:
- Reset: rst_n=0 with inp=32'hDDCCBBAA, en=1, mode=1 -> outp=0, sel_cur=0, out_valid=0, wrap=0, err=0 throughout reset. Release -> first edge gives outp=8'hAA.
- Manual sweep: NCH=4, inp=32'h44332211, mode=0, sel_in 0,1,2,3 on consecutive edges -> outp 11,22,33,44 one cycle late; sel_cur tracks; out_valid=1.
- Scan wrap: DWELL=4, mode=1, en=1 for 20 edges -> outp shows channel 0 for 4 cycles, then 1,2,3, then 0. wrap high exactly once, in the cycle after edge 16.
- Enable pause: scan with en=0 for 5 cycles mid-channel-2 -> outp and sel_cur frozen, out_valid=0. Resume completes the remaining channel-2 dwell.
- Invalid select: NCH=3, SELW=2, mode=0, sel_in=3 -> err=1 for one cycle, out_valid=0, outp holds the prior value.
- Async reset mid-scan: assert rst_n between edges while sel_cur=2 -> outputs clear without a clock edge. Scan restarts at channel 0 after release.
